// File: rtl/pixel_out_frame_fifo_if.sv
// Pixel stream interface for pixel_out_frame_fifo.
// The slave modport is the FIFO's side. The master modport is the side that feeds pixels
// in and drains the tagged stream.
interface pixel_out_frame_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [23:0]   in_rgb;
  logic          in_valid;
  logic          almost_full;
  logic [23:0]   out_rgb;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          overflow;
  logic          frame_done;
  logic [31:0]   checksum;

  modport slave (
    input  in_rgb, in_valid, out_ready,
    output almost_full, out_rgb, out_sof, out_eol, out_eof, out_valid,
           level, overflow, frame_done, checksum
  );

  modport master (
    output in_rgb, in_valid, out_ready,
    input  almost_full, out_rgb, out_sof, out_eol, out_eof, out_valid,
           level, overflow, frame_done, checksum
  );
endinterface

// File: rtl/pixel_out_frame_fifo.sv
// pixel_out_frame_fifo: captures corrected pixels into a first-word-fall-through FIFO.
// Each pixel gets SOF/EOL/EOF tags at write time. The FIFO then re-emits the tagged pixels
// on a valid/ready stream.
// The input has no back-pressure. A pixel that arrives while the FIFO is full, and no pop
// happens in that cycle, is dropped and sets the sticky overflow flag.
// Optional feature: define PIXEL_CHECKSUM_EN to enable the per-frame rotate-xor signature.
// Without it, checksum is tied to 0.
module pixel_out_frame_fifo #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int DEPTH        = 16,
  parameter int AF_MARGIN    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pixel_out_frame_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [23:0] rgb;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          almost_full_q, overflow_q, frame_done_q;
  logic          full, empty, pop, push, drop;
  logic          col_last, row_last;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign pop       = !empty && bus.out_ready;
  assign push      = bus.in_valid && (!full || pop);
  assign drop      = bus.in_valid && full && !pop;
  assign level_nxt = level_q + LW'(push) - LW'(pop);

  assign col_last  = (col == CW'(IMAGE_WIDTH - 1));
  assign row_last  = (row == RW'(IMAGE_HEIGHT - 1));
  assign wr_entry  = {(col == '0) && (row == '0), col_last, col_last && row_last, bus.in_rgb};
  assign head      = mem[rd_ptr];

  // Storage array. Only occupied slots are ever observed, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q       <= level_nxt;
      almost_full_q <= (level_nxt >= LW'(DEPTH - AF_MARGIN));
      overflow_q    <= overflow_q | drop;
      frame_done_q  <= pop && head.eof;
    end
  end

  // Frame geometry. The counters advance on every input pixel, dropped ones included,
  // so the tags stay aligned with the upstream frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef PIXEL_CHECKSUM_EN
  logic [31:0] csum_q, csum_nxt, checksum_q;

  // Running signature of the frame being drained. An SOF pixel restarts it.
  always_comb begin
    csum_nxt = head.sof ? {8'h0, head.rgb}
                        : ({csum_q[30:0], csum_q[31]} ^ {8'h0, head.rgb});
  end

  // Advance on every pop. Publish the signature when the EOF pixel leaves the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q     <= '0;
      checksum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_nxt;
      if (head.eof) checksum_q <= csum_nxt;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = 32'h0;
`endif

  // Head fields are forced to zero while the FIFO is empty, so every output reads 0 out of reset.
  assign bus.out_valid   = !empty;
  assign bus.out_rgb     = empty ? 24'h0 : head.rgb;
  assign bus.out_sof     = !empty && head.sof;
  assign bus.out_eol     = !empty && head.eol;
  assign bus.out_eof     = !empty && head.eof;
  assign bus.level       = level_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_done  = frame_done_q;
endmodule
